// File: rtl/accumulator_processor.sv
// accumulator_processor: bus initiator that fetches operand pairs from
// memory, adds them and writes the sum back until memory runs dry.
// Ports: clk, reset (async, active-high), start, grant/req (arbiter),
// op/data (shared tristate bus), busy, done, err (sticky timeout),
// result, adds (addition count), dbg_id (ID[7:0]).
// Optional: define ACC_SATURATE_EN to clamp sums at 32'hFFFFFFFF.
module accumulator_processor #(
  parameter int unsigned TIMEOUT = 2048,
  parameter int unsigned ID      = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        grant,
  output logic        req,
  inout  wire  [1:0]  op,
  inout  wire  [31:0] data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result,
  output logic [15:0] adds,
  output logic [7:0]  dbg_id
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  localparam logic [1:0] OP_FETCH = 2'b01;
  localparam logic [1:0] OP_SEND  = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  typedef enum logic [3:0] {
    IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B,
    ADD, REQ_S, WAIT_S, FIN
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   sum_q, sum_d;
  logic [31:0]   result_q, result_d;
  logic [15:0]   adds_q, adds_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          end_seen;
  logic          in_wait;
  logic          tmo;
  logic [31:0]   add_res;
  logic          op_oe;
  logic          data_oe;
  logic [1:0]    op_val;

`ifdef ACC_SATURATE_EN
  logic [32:0] add_full;
  assign add_full = {1'b0, a_q} + {1'b0, b_q};
  assign add_res  = add_full[32] ? 32'hFFFF_FFFF : add_full[31:0];
`else
  assign add_res = a_q + b_q;
`endif

  assign end_seen = (op == OP_END);
  assign in_wait  = (state_q == WAIT_A) || (state_q == WAIT_B) ||
                    (state_q == WAIT_S);
  assign tmo      = in_wait && (timer_q == TMAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      result_q <= '0;
      adds_q   <= '0;
      err_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      adds_q   <= adds_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    result_d = result_q;
    adds_d   = adds_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE:   if (start) state_d = REQ_A;
      REQ_A:  if (grant) state_d = WAIT_A;
      REQ_B:  if (grant) state_d = WAIT_B;
      REQ_S:  if (grant) state_d = WAIT_S;
      WAIT_A: begin
        if (end_seen) begin
          a_d = data;
          if (data == '0) begin
            // exhausted: the last operand fetched is the answer
            result_d = a_q;
            state_d  = FIN;
          end else begin
            state_d = REQ_B;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = FIN;
        end
      end
      WAIT_B: begin
        if (end_seen) begin
          b_d = data;
          if (data == '0) begin
            // lone operand: write it back unchanged
            result_d = a_q;
            sum_d    = a_q;
            state_d  = REQ_S;
          end else begin
            state_d = ADD;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = FIN;
        end
      end
      ADD: begin
        sum_d   = add_res;
        adds_d  = adds_q + 16'd1;
        state_d = REQ_S;
      end
      WAIT_S: begin
        if (end_seen) begin
          result_d = sum_q;
          state_d  = REQ_A;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = FIN;
        end
      end
      FIN:     state_d = FIN;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
    else if (in_wait)       timer_d = timer_q + 1'b1;
    else                    timer_d = timer_q;
  end

  always_comb begin
    req     = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    op_oe   = 1'b0;
    op_val  = OP_FETCH;
    data_oe = 1'b0;
    unique case (state_q)
      IDLE: busy = 1'b0;
      REQ_A, REQ_B: begin
        req   = 1'b1;
        op_oe = grant;
      end
      WAIT_A, WAIT_B, ADD: req = 1'b1;
      REQ_S: begin
        req     = 1'b1;
        op_oe   = grant;
        op_val  = OP_SEND;
        data_oe = grant;
      end
      WAIT_S: begin
        req     = 1'b1;
        data_oe = 1'b1;
      end
      FIN: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign op   = op_oe   ? op_val : 2'bzz;
  assign data = data_oe ? sum_q  : 32'bz;

  assign err    = err_q;
  assign result = result_q;
  assign adds   = adds_q;
  assign dbg_id = 8'(ID);

endmodule
